// File: rtl/idma_req_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumReq frontends.
// An in-order route FIFO steers backend responses to the requester of each transfer.

module idma_req_arbiter_chk #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              lock_i,
  input logic [IdxW-1:0]   locked_idx_i,
  input logic [NumReq-1:0] req_valid_i,
  input logic              rsp_valid_i,
  input logic              fifo_empty_i
);

  a_hold_locked_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_i |-> req_valid_i[locked_idx_i])
    else $error("idma_req_arbiter: locked frontend dropped its request");

  a_rsp_needs_route: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_i |-> !fifo_empty_i)
    else $error("idma_req_arbiter: backend response with nothing outstanding");

endmodule

module idma_req_arbiter #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RspWidth       = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*ReqWidth-1:0] req_i,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [ReqWidth-1:0]        req_o,
  input  logic                       rsp_valid_i,
  output logic                       rsp_ready_o,
  input  logic [RspWidth-1:0]        rsp_i,
  output logic [NumReq-1:0]          rsp_valid_o,
  input  logic [NumReq-1:0]          rsp_ready_i,
  output logic [RspWidth-1:0]        rsp_o,
  output logic [CntW-1:0]            outstanding_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(NumReq - 1)) begin
      return IdxW'(0);
    end else begin
      return idx + IdxW'(1);
    end
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MaxOutstanding - 1)) begin
      return PtrW'(0);
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  logic              en_q;
  logic              lock_q, lock_d;
  logic [IdxW-1:0]   locked_idx_q, locked_idx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   route_q [MaxOutstanding];
  logic [IdxW-1:0]   route_d [MaxOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [IdxW-1:0]   cand_s;
  logic [IdxW-1:0]   rr_grant_s;
  logic [IdxW-1:0]   grant_s;
  logic [IdxW-1:0]   head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              req_valid_s;
  logic              rsp_ready_s;
  logic              push_s;
  logic              pop_s;

  // Round-robin search; walking backwards lets the closest requester to rr_ptr win last.
  always_comb begin
    cand_s     = IdxW'(0);
    rr_grant_s = rr_ptr_q;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      cand_s     = IdxW'((32'(rr_ptr_q) + 32'(i)) % NumReq);
      rr_grant_s = req_valid_i[cand_s] ? cand_s : rr_grant_s;
    end
  end

  // Grant selection, FIFO status and handshake qualification.
  always_comb begin
    grant_s      = lock_q ? locked_idx_q : rr_grant_s;
    fifo_full_s  = (cnt_q == CntW'(MaxOutstanding));
    fifo_empty_s = (cnt_q == CntW'(0));
    // A pop in the same cycle never reopens a full FIFO: keeps rsp_* off the req_* path.
    req_valid_s  = en_q & ((|req_valid_i) | lock_q) & ~fifo_full_s;
    push_s       = req_valid_s & req_ready_i;
    head_s       = route_q[rd_ptr_q];
    rsp_ready_s  = en_q & rsp_ready_i[head_s] & ~fifo_empty_s;
    pop_s        = rsp_valid_i & rsp_ready_s;
  end

  // Output steering towards backend and frontends.
  always_comb begin
    req_valid_o          = req_valid_s;
    req_o                = req_i[32'(grant_s)*ReqWidth +: ReqWidth];
    req_ready_o          = {NumReq{1'b0}};
    req_ready_o[grant_s] = push_s;
    rsp_ready_o          = rsp_ready_s;
    rsp_valid_o          = {NumReq{1'b0}};
    rsp_valid_o[head_s]  = en_q & rsp_valid_i & ~fifo_empty_s;
    rsp_o                = rsp_i;
    outstanding_o        = cnt_q;
    busy_o               = req_valid_s | ~fifo_empty_s;
  end

  // Lock and round-robin pointer next state.
  always_comb begin
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    rr_ptr_d     = rr_ptr_q;
    if (push_s) begin
      lock_d   = 1'b0;
      rr_ptr_d = next_idx(grant_s);
    end else if (req_valid_s) begin
      lock_d       = 1'b1;
      locked_idx_d = grant_s;
    end else begin
      lock_d = lock_q;
    end
  end

  // Route FIFO next state.
  always_comb begin
    route_d  = route_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      route_d[wr_ptr_q] = grant_s;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; en_q keeps every handshake output low during and just after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q         <= 1'b0;
      lock_q       <= 1'b0;
      locked_idx_q <= IdxW'(0);
      rr_ptr_q     <= IdxW'(0);
      route_q      <= '{default: IdxW'(0)};
      wr_ptr_q     <= PtrW'(0);
      rd_ptr_q     <= PtrW'(0);
      cnt_q        <= CntW'(0);
    end else begin
      en_q         <= 1'b1;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      route_q      <= route_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  idma_req_arbiter_chk #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lock_i       (lock_q),
    .locked_idx_i (locked_idx_q),
    .req_valid_i  (req_valid_i),
    .rsp_valid_i  (rsp_valid_i),
    .fifo_empty_i (fifo_empty_s)
  );

endmodule

// File: tb/tb_idma_req_arbiter.sv
// Bench for idma_req_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.

module tb_idma_req_arbiter;

  localparam int N  = 3;
  localparam int RW = 128;
  localparam int SW = 32;
  localparam int MO = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*RW-1:0] req_i;
  logic            req_valid_o;
  logic            req_ready_i;
  logic [RW-1:0]   req_o;
  logic            rsp_valid_i;
  logic            rsp_ready_o;
  logic [SW-1:0]   rsp_i;
  logic [N-1:0]    rsp_valid_o;
  logic [N-1:0]    rsp_ready_i;
  logic [SW-1:0]   rsp_o;
  logic [CW-1:0]   outstanding_o;
  logic            busy_o;

  logic [RW-1:0]   req_data [N];

  int total, bad;
  int m_rr, m_lock, m_lidx, last_hs;
  int route_q[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign req_i[k*RW +: RW] = req_data[k];
  end

  idma_req_arbiter #(
    .NumReq(N), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_o(req_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_i(rsp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_o(rsp_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lidx = 0; last_hs = -1;
    route_q.delete();
  endtask

  // One clock cycle: check all outputs against the model, clock, then advance the model.
  task automatic step();
    int g, c, sz, head;
    bit ev, erdy;
    logic [N-1:0] ers, erv;
    #1;
    sz = route_q.size();
    g  = m_lock ? m_lidx : -1;
    if (!m_lock) begin
      for (int o = 0; o < N; o++) begin
        c = (m_rr + o) % N;
        if (g < 0 && req_valid_i[c]) g = c;
      end
    end
    ev = ((req_valid_i != 0) || (m_lock != 0)) && (sz < MO);
    check("req_valid_o", req_valid_o, ev);
    if (ev) check("req_o", req_o, req_data[g]);
    ers = '0;
    if (ev && req_ready_i) ers[g] = 1'b1;
    check("req_ready_o", req_ready_o, ers);
    head = (sz > 0) ? route_q[0] : 0;
    erdy = (sz > 0) && rsp_ready_i[head];
    erv  = '0;
    if (sz > 0 && rsp_valid_i) erv[head] = 1'b1;
    check("rsp_ready_o", rsp_ready_o, erdy);
    check("rsp_valid_o", rsp_valid_o, erv);
    check("rsp_o", rsp_o, rsp_i);
    check("outstanding_o", outstanding_o, sz);
    check("busy_o", busy_o, ev || (sz > 0));
    @(posedge clk);
    last_hs = -1;
    if (rsp_valid_i && erdy) void'(route_q.pop_front());
    if (ev && req_ready_i) begin
      route_q.push_back(g);
      m_lock = 0; m_rr = (g + 1) % N; last_hs = g;
    end else if (ev) begin
      m_lock = 1; m_lidx = g;
    end
    #1;
  endtask

  task automatic drain();
    req_valid_i = '0; rsp_valid_i = 1'b1; rsp_ready_i = 3'b111;
    for (int i = 0; i < 20 && route_q.size() > 0; i++) step();
    rsp_valid_i = 1'b0;
    #1 check("drain_count", outstanding_o, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_valid"}, req_valid_o, 1'b0);
    check({tag, "_req_ready"}, req_ready_o, 3'b000);
    check({tag, "_rsp_valid"}, rsp_valid_o, 3'b000);
    check({tag, "_rsp_ready"}, rsp_ready_o, 1'b0);
    check({tag, "_outstanding"}, outstanding_o, 0);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    model_reset();
    for (int k = 0; k < N; k++) req_data[k] = {4{32'h1111_1111 * 32'(k + 1)}};
    rst_ni = 1'b0; req_valid_i = 3'b111; req_ready_i = 1'b1;
    rsp_valid_i = 1'b1; rsp_ready_i = 3'b111; rsp_i = 32'hCAFE_0001;
    #12 check_idle("reset");
    req_valid_i = '0; rsp_valid_i = 1'b0;
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;

    // Round-robin fairness and in-order routing
    req_valid_i = 3'b111; req_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_grant", req_ready_o, 3'b001 << (i % 3));
      step();
    end
    #1 check("rr_count", outstanding_o, 6);
    req_valid_i = '0; rsp_valid_i = 1'b1; rsp_ready_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_route", rsp_valid_o, 3'b001 << (i % 3));
      step();
    end
    rsp_valid_i = 1'b0;

    // Lock: requester 0 stalled while requester 1 (now higher priority) raises
    req_valid_i = 3'b001; req_ready_i = 1'b1; step();
    req_data[0] = {4{32'h0BAD_F00D}};
    req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) req_valid_i = 3'b011;
      #1 check("lock_req_o", req_o, {4{32'h0BAD_F00D}});
      check("lock_ready1", req_ready_o[1], 1'b0);
      step();
    end
    req_ready_i = 1'b1;
    #1 check("lock_handshake", req_ready_o, 3'b001);
    step();
    req_valid_i = 3'b010;
    #1 check("lock_next", req_ready_o, 3'b010);
    step();
    drain();

    // Full route FIFO blocks requests; one pop reopens the cycle after
    req_valid_i = 3'b111; req_ready_i = 1'b1;
    for (int i = 0; i < MO; i++) step();
    #1 check("full_count", outstanding_o, 8);
    check("full_valid", req_valid_o, 1'b0);
    check("full_ready", req_ready_o, 3'b000);
    rsp_valid_i = 1'b1; rsp_ready_i = 3'b111;
    #1 check("full_pop_valid", req_valid_o, 1'b0);
    step();
    rsp_valid_i = 1'b0;
    #1 check("full_reopen", req_valid_o, 1'b1);
    check("full_count7", outstanding_o, 7);
    step();
    drain();

    // Response backpressure from head owner 2
    req_valid_i = 3'b100; req_ready_i = 1'b1; step();
    req_valid_i = '0; rsp_valid_i = 1'b1; rsp_ready_i = 3'b001; rsp_i = 32'h5A5A_0002;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", rsp_ready_o, 1'b0);
      check("bp_valid", rsp_valid_o, 3'b100);
      step();
    end
    #1 check("bp_count", outstanding_o, 1);
    rsp_ready_i = 3'b100;
    #1 check("bp_release", rsp_ready_o, 1'b1);
    step();
    rsp_valid_i = 1'b0;

    // Simultaneous push and pop at count 4
    req_valid_i = 3'b111; req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rsp_valid_i = 1'b1; rsp_ready_i = 3'b111; step();
    rsp_valid_i = 1'b0; req_valid_i = '0;
    #1 check("pp_count", outstanding_o, 4);
    drain();

    // Random traffic with protocol-compliant frontends and backend
    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
          req_valid_i[k] = 1'b1;
          req_data[k] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      req_ready_i = ($urandom_range(0, 3) != 0);
      rsp_valid_i = (route_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rsp_ready_i = 3'($urandom);
      rsp_i = $urandom;
      step();
      if (last_hs >= 0) req_valid_i[last_hs] = 1'b0;
    end

    // Reset in the middle of traffic
    req_valid_i = 3'b111; rsp_valid_i = (route_q.size() > 0);
    #3 rst_ni = 1'b0;
    #1 check_idle("midreset");
    model_reset();
    req_valid_i = '0; rsp_valid_i = 1'b0;
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 3'b111; req_ready_i = 1'b1;
    #1 check("post_reset_grant", req_ready_o, 3'b001);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
